// File: rtl/divider_pkg.sv
// Shared types and constants for the restoring divider slice.
package divider_pkg;

    localparam int unsigned DIV_ITERS = 32;
    localparam logic [DIV_ITERS-1:0] DIV0_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: trial subtraction of D from the shifted
// partial remainder on a Kogge-Stone prefix subtractor, restore on borrow.
module div_step
    import divider_pkg::*;
#(
    parameter int unsigned width = DIV_ITERS
) (
    input  logic [width-1:0] r_in,
    input  logic             q_msb,
    input  logic [width-1:0] d_in,
    output logic [width-1:0] r_out,
    output logic             q_bit
);

    localparam int unsigned TW     = width + 1;
    localparam int unsigned LEVELS = $clog2(width);

    logic [TW-1:0]    a;
    logic [TW-1:0]    b_n;
    logic [TW-1:0]    prop;
    logic [TW-1:0]    diff;
    logic [width-1:0] gen;
    logic [width-1:0] gg;
    logic [width-1:0] pp;

    always_comb begin
        a    = {r_in, q_msb};
        b_n  = ~{1'b0, d_in};
        prop = a ^ b_n;
        gen  = a[width-1:0] & b_n[width-1:0];
        // carry-in of 1 (two's complement) folded into bit 0's generate
        gg    = gen;
        gg[0] = gen[0] | prop[0];
        pp    = prop[width-1:0];
        for (int unsigned lvl = 0; lvl < LEVELS; lvl++) begin
            for (int unsigned k = 0; k + (32'd1 << lvl) < width; k++) begin
                gg[width-1-k] = gg[width-1-k] | (pp[width-1-k] & gg[width-1-k-(32'd1 << lvl)]);
                pp[width-1-k] = pp[width-1-k] & pp[width-1-k-(32'd1 << lvl)];
            end
        end
        diff[0]      = ~prop[0];
        diff[TW-1:1] = prop[TW-1:1] ^ gg;
        q_bit        = ~diff[TW-1];
        r_out        = q_bit ? diff[width-1:0] : a[width-1:0];
    end

endmodule

// File: rtl/divider_restoring_32.sv
// Multi-cycle restoring divider with start/done handshake, one quotient bit
// per cycle. Optional signed mode via DIVIDER_SIGNED_EN.
module divider_restoring_32
    import divider_pkg::*;
#(
    parameter int unsigned width = DIV_ITERS
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
`ifdef DIVIDER_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CNT_W = $clog2(width);

    div_state_e       state_q, state_d;
    logic [width-1:0] q_q, q_d;
    logic [width-1:0] r_q, r_d;
    logic [width-1:0] dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [width-1:0] quotient_q, quotient_d;
    logic [width-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             ready_q, ready_d;

    logic [width-1:0] dvd_mag;
    logic [width-1:0] dvs_mag;
    logic [width-1:0] step_r;
    logic             step_bit;
    logic [width-1:0] q_fin;
    logic             neg_quo_q;
    logic             neg_rem_q;

`ifdef DIVIDER_SIGNED_EN
    logic neg_quo_d;
    logic neg_rem_d;
    logic accept;

    always_comb begin
        dvd_mag   = (is_signed && dividend[width-1]) ? (~dividend + 1'b1) : dividend;
        dvs_mag   = (is_signed && divisor[width-1])  ? (~divisor + 1'b1)  : divisor;
        accept    = ((state_q == IDLE) || (state_q == DONE)) && start && (divisor != '0);
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        if (accept) begin
            neg_quo_d = is_signed && (dividend[width-1] ^ divisor[width-1]);
            neg_rem_d = is_signed && dividend[width-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    assign dvd_mag   = dividend;
    assign dvs_mag   = divisor;
    assign neg_quo_q = 1'b0;
    assign neg_rem_q = 1'b0;
`endif

    div_step #(
        .width (width)
    ) u_step (
        .r_in  (r_q),
        .q_msb (q_q[width-1]),
        .d_in  (dvsr_q),
        .r_out (step_r),
        .q_bit (step_bit)
    );

    assign q_fin = {q_q[width-2:0], step_bit};

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        r_d         = r_q;
        dvsr_d      = dvsr_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        ready_d     = ready_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
                if (start) begin
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = DIV0_QUOTIENT;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        state_d = RUN;
                        q_d     = dvd_mag;
                        dvsr_d  = dvs_mag;
                        r_d     = '0;
                        cnt_d   = CNT_W'(width - 1);
                        busy_d  = 1'b1;
                        ready_d = 1'b0;
                    end
                end
            end
            RUN: begin
                q_d   = q_fin;
                r_d   = step_r;
                cnt_d = cnt_q - 1'b1;
                // final iteration publishes straight from the step outputs
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = neg_quo_q ? (~q_fin + 1'b1) : q_fin;
                    remainder_d = neg_rem_q ? (~step_r + 1'b1) : step_r;
                    dbz_d       = 1'b0;
                    done_d      = 1'b1;
                    busy_d      = 1'b0;
                    ready_d     = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            q_q         <= '0;
            r_q         <= '0;
            dvsr_q      <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            r_q         <= r_d;
            dvsr_q      <= dvsr_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign ready       = ready_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/divider_restoring_32.md
Name: divider_restoring_32

Overview:
- Multi-cycle unsigned 32-bit restoring divider that consumes the team's 32-bit prefix subtractor datapath: one trial subtraction per cycle, one quotient bit per cycle.
- Sits downstream of the subtractor as the sequential consumer used by the ALU/EX stage for DIV/REM operations.
- Uses a start/done handshake with a busy indication; results are held until the next accepted start.

Parameters:
- width, 32, operand/result width; iteration count equals width.

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request; accepted only when ready=1
- dividend  input  width  numerator, sampled on accepting edge
- divisor  input  width  denominator, sampled on accepting edge
- ready  output  1  high in IDLE and DONE; start accepted
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  width  result, held until next accepted start
- remainder  output  width  result, held until next accepted start
- div_by_zero  output  1  set with done when divisor==0; held like results

Behaviour:
- Reset (async, reset_n=0): state=IDLE; quotient, remainder, div_by_zero, done, busy all 0; ready=1.
- States: IDLE, RUN, DONE.
- IDLE/DONE with start=1 and divisor!=0:
  - latch dividend into quotient shift reg Q and divisor into D; clear partial remainder R (width+1 bits); count=width-1; go RUN.
- IDLE/DONE with start=1 and divisor==0:
  - go DONE next edge; quotient=all ones; remainder=dividend; div_by_zero=1; no RUN cycles.
- RUN, each cycle:
  - T = {R[width-1:0], Q[width-1]} - {1'b0, D}, computed width+1 bits wide.
  - If T is non-negative (T[width]==0): R=T and shift 1 into Q LSB; else keep shifted R and shift 0 into Q LSB.
  - count decrements; on count==0 go DONE.
- DONE: done=1 for exactly this cycle; quotient=Q, remainder=R[width-1:0]; then IDLE unless start=1, which re-launches directly (back-to-back allowed).
- Latency: start accepted at edge k, done high in the cycle after edge k+width+1 (33 cycles for width=32); divide-by-zero done after edge k+1.
- start while busy: ignored, no queuing; operands not resampled.
- Outputs change only at done; intermediate Q/R never visible on quotient/remainder.
- reset_n asserted mid-RUN: immediate abort to reset values; no done pulse.
- Dividend < divisor: quotient=0, remainder=dividend. Divisor=1: quotient=dividend, remainder=0.

Optional Feature:
- Macro: DIVIDER_SIGNED_EN.
- Defined:
  - extra input is_signed (1 bit), sampled with start.
  - When is_signed=1, operands are converted to magnitudes at accept; in DONE, quotient is negated if the operand signs differ and remainder takes the dividend's sign.
  - Overflow case 0x80000000 / 0xFFFFFFFF gives quotient=0x80000000, remainder=0, no special flag.
  - Divide-by-zero results are identical to unsigned.
  - Latency unchanged.
- Undefined: port absent; all operation unsigned.

Decomposition:
- Package divider_pkg: state enum type (IDLE, RUN, DONE); localparam DIV_ITERS=width; localparam for the all-ones divide-by-zero quotient.
- Sub-module div_step: combinational single iteration with inputs R, Q MSB and D, and outputs next R and quotient bit. It wraps the width+1 trial subtraction on the prefix-subtractor structure.

Test Plan:
- 980 / 722 -> quotient=1, remainder=258, div_by_zero=0; done exactly 33 cycles after start edge.
- 0xFFFFFFFF / 5 -> quotient=0x33333333, remainder=0; then 10001 / 2 back-to-back started in DONE -> quotient=5000, remainder=1.
- 7 / 0 -> done after 1 cycle, quotient=0xFFFFFFFF, remainder=7, div_by_zero=1; next op 100 / 50 -> quotient=2, remainder=0, div_by_zero=0.
- start 100 / 50, pulse start again with 9 / 3 in cycle 5 of RUN -> second start ignored, result 2 r 0; reset_n low in cycle 10 of a new op -> outputs 0, no done, ready=1.
- 0 / 1 -> quotient=0, remainder=0; 1 / 0xFFFFFFFF -> quotient=0, remainder=1.
- (DIVIDER_SIGNED_EN) is_signed=1: -7 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
